ibuf_ctrl: RTL

Sequencing controller for the CIM input buffer (`ibuf`). It accepts a valid/ready stream of `datatype_size`-bit operands and drives the buffer write strobe and data. After exactly `fifo_length` operands have been loaded, it issues a one-cycle start pulse to the crossbar compute stage. It then stalls the stream until the crossbar reports done. It sits between the host/DMA stream and the `ibuf` + crossbar pair, and guarantees that the buffer is never overwritten mid-computation.

---
 rtl/ibuf_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/ibuf_ctrl.sv
// Input-buffer sequencing controller: loads fifo_length operands into ibuf,
// fires a one-cycle crossbar start, then holds the stream off until done.
module ibuf_ctrl #(
    parameter int datatype_size = 8,
    parameter int fifo_length   = 5,
    parameter int cnt_width     = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               i_valid,
    input  logic [datatype_size-1:0]           i_data,
    output logic                               o_ready,
    output logic                               o_ibuf_we,
    output logic [datatype_size-1:0]           o_ibuf_data,
    output logic                               o_cim_start,
    input  logic                               i_cim_done,
    input  logic                               i_clear,
    output logic                               o_busy,
    output logic [$clog2(fifo_length+1)-1:0]   o_fill_count,
    output logic [cnt_width-1:0]               o_vec_count
);

    localparam int fill_width = $clog2(fifo_length + 1);
    localparam logic [fill_width-1:0] last_fill = fill_width'(fifo_length - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        START,
        WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [fill_width-1:0]  fill_q, fill_d;
    logic [cnt_width-1:0]   vec_q, vec_d;
    logic                   accept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            fill_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        vec_d       = vec_q;
        accept      = 1'b0;
        o_ready     = 1'b0;
        o_ibuf_we   = 1'b0;
        o_ibuf_data = '0;
        o_cim_start = 1'b0;
        o_busy      = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FILL;
            end
            FILL: begin
                o_ready     = 1'b1;
                accept      = i_valid;
                o_ibuf_we   = accept;
                o_ibuf_data = accept ? i_data : '0;
                if (accept) begin
                    if (fill_q == last_fill) begin
                        fill_d  = '0;
                        state_d = START;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            START: begin
                o_cim_start = 1'b1;
                o_busy      = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                if (i_cim_done) begin
                    vec_d   = vec_q + 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every transition above; a write seen this cycle still
        // reaches the port but is dropped from the count, and the vector tally is kept.
        if (i_clear && state_q != IDLE) begin
            state_d = FILL;
            fill_d  = '0;
            vec_d   = vec_q;
        end
    end

    assign o_fill_count = fill_q;
    assign o_vec_count  = vec_q;

endmodule
